// File: rtl/sdf_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sdf_stage_ctrl
// Brief    : Sequencer for one radix-2 single-delay-feedback FFT stage.
//            Tracks frames of 2*DELAY samples and drives the load/butterfly/
//            drain muxes, shift-register enable, twiddle-ROM address and
//            output valid of the stage datapath.
// Revision : 1.0  initial release
// ============================================================================
module sdf_stage_ctrl #(
    parameter int DELAY   = 8,  // half-frame length = shift-register depth
    parameter int TW_STEP = 2,  // twiddle address stride per drain sample
    parameter int AW      = 4   // twiddle address width
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    input  logic          clr_err_i,
    output logic [1:0]    state_o,
    output logic          bf_mode_o,
    output logic          sr_sel_o,
    output logic          sr_shift_o,
    output logic          tw_en_o,
    output logic [AW-1:0] tw_addr_o,
    output logic          valid_o,
    output logic          frame_done_o,
    output logic          err_o
);

    // Counter width must hold the value 2*DELAY, reached transiently before
    // the wrap to DRAIN.
    localparam int CW = $clog2(2 * DELAY) + 1;

    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_D   = CW'(DELAY);
    localparam logic [CW-1:0] C_2D  = CW'(2 * DELAY);
    localparam logic [CW-1:0] C_DM1 = CW'(DELAY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_BFLY  = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_in_cnt;
    logic [CW-1:0] w_in_cnt_nxt;
    logic [CW-1:0] r_drn_cnt;
    logic [CW-1:0] w_drn_cnt_nxt;
    logic [CW-1:0] w_in_inc;
    logic          r_err;
    logic          w_err_set;
    logic          w_bfly;
    logic          w_drain;
    logic [AW-1:0] w_tw_addr;

    assign w_in_inc = r_in_cnt + C_ONE;

    // State, counters and sticky error register; reset may arrive mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_in_cnt  <= '0;
            r_drn_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_in_cnt  <= w_in_cnt_nxt;
            r_drn_cnt <= w_drn_cnt_nxt;
            // A protocol error in the same cycle as a clear keeps the flag set.
            r_err     <= w_err_set | (r_err & ~clr_err_i);
        end
    end

    // Next-state and counter update; DRAIN overlaps loading of the next frame.
    always_comb begin
        w_state_nxt   = r_state;
        w_in_cnt_nxt  = r_in_cnt;
        w_drn_cnt_nxt = r_drn_cnt;
        w_err_set     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (valid_i) begin
                    w_in_cnt_nxt = C_ONE;
                    w_state_nxt  = (C_D == C_ONE) ? ST_BFLY : ST_FILL;
                end
            end
            ST_FILL: begin
                if (valid_i) begin
                    w_in_cnt_nxt = w_in_inc;
                    if (w_in_inc == C_D) begin
                        w_state_nxt = ST_BFLY;
                    end
                end else begin
                    w_err_set    = 1'b1;
                    w_in_cnt_nxt = '0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_BFLY: begin
                if (valid_i) begin
                    if (w_in_inc == C_2D) begin
                        w_in_cnt_nxt  = '0;
                        w_drn_cnt_nxt = '0;
                        w_state_nxt   = ST_DRAIN;
                    end else begin
                        w_in_cnt_nxt = w_in_inc;
                    end
                end else begin
                    w_err_set    = 1'b1;
                    w_in_cnt_nxt = '0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                w_drn_cnt_nxt = r_drn_cnt + C_ONE;
                // A gap after a partial early load discards that partial load.
                if (valid_i) begin
                    w_in_cnt_nxt = w_in_inc;
                end else begin
                    if (r_in_cnt != '0) begin
                        w_err_set = 1'b1;
                    end
                    w_in_cnt_nxt = '0;
                end
                // Exit depends on how much of the next frame has been loaded.
                if (r_drn_cnt == C_DM1) begin
                    w_drn_cnt_nxt = '0;
                    if (w_in_cnt_nxt == C_D) begin
                        w_state_nxt = ST_BFLY;
                    end else if (w_in_cnt_nxt == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_in_cnt_nxt  = '0;
                w_drn_cnt_nxt = '0;
            end
        endcase
    end

    assign w_bfly  = (r_state == ST_BFLY);
    assign w_drain = (r_state == ST_DRAIN);

    // Product taken modulo 2**AW; operands reduced first, which is exact.
    assign w_tw_addr = AW'(r_drn_cnt) * AW'(TW_STEP);

    assign state_o      = r_state;
    assign bf_mode_o    = w_bfly;
    assign sr_sel_o     = w_bfly;
    assign sr_shift_o   = valid_i | w_drain;
    assign tw_en_o      = w_drain;
    assign tw_addr_o    = w_drain ? w_tw_addr : '0;
    assign valid_o      = (w_bfly & valid_i) | w_drain;
    assign frame_done_o = w_drain & (r_drn_cnt == C_DM1);
    assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sdf_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdf_stage_ctrl
// Brief    : Self-checking bench for sdf_stage_ctrl (DELAY=8 and DELAY=1).
// Revision : 1.0  initial release
// ============================================================================
module tb_sdf_stage_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic v8, c8, v1, c1;

    logic [1:0] st8, st1;
    logic       bf8, sel8, sh8, twe8, vo8, fd8, er8;
    logic       bf1, sel1, sh1, twe1, vo1, fd1, er1;
    logic [3:0] ad8, ad1;
    logic [12:0] o8, o1;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    sdf_stage_ctrl #(.DELAY(8), .TW_STEP(2), .AW(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .valid_i(v8), .clr_err_i(c8),
        .state_o(st8), .bf_mode_o(bf8), .sr_sel_o(sel8), .sr_shift_o(sh8),
        .tw_en_o(twe8), .tw_addr_o(ad8), .valid_o(vo8),
        .frame_done_o(fd8), .err_o(er8)
    );

    sdf_stage_ctrl #(.DELAY(1), .TW_STEP(16), .AW(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .valid_i(v1), .clr_err_i(c1),
        .state_o(st1), .bf_mode_o(bf1), .sr_sel_o(sel1), .sr_shift_o(sh1),
        .tw_en_o(twe1), .tw_addr_o(ad1), .valid_o(vo1),
        .frame_done_o(fd1), .err_o(er1)
    );

    assign o8 = {st8, bf8, sel8, sh8, twe8, ad8, vo8, fd8, er8};
    assign o1 = {st1, bf1, sel1, sh1, twe1, ad1, vo1, fd1, er1};

    // Model: samples held for the frame being built, and position in the
    // drain of the previous frame (-1 when not draining).
    typedef struct packed {
        int   filled;
        int   dpos;
        logic err;
    } mdl_t;

    mdl_t m8, m1;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.filled = 0;
        m.dpos   = -1;
        m.err    = 1'b0;
        return m;
    endfunction

    function automatic logic [12:0] mdl_out(input mdl_t m, input int d,
                                            input int tw, input logic v);
        int         st;
        logic       bf, sh, twe, vo, fd;
        logic [3:0] ad;
        if (m.dpos >= 0)      st = 3;
        else if (m.filled == 0) st = 0;
        else if (m.filled < d)  st = 1;
        else                  st = 2;
        bf  = (st == 2);
        sh  = v || (st == 3);
        twe = (st == 3);
        ad  = (st == 3) ? 4'((m.dpos * tw) % 16) : 4'd0;
        vo  = (st == 2 && v) || (st == 3);
        fd  = (st == 3) && (m.dpos == d - 1);
        return {2'(st), bf, bf, sh, twe, ad, vo, fd, m.err};
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int d,
                                      input logic v, input logic clr);
        mdl_t n;
        bit   es;
        n  = m;
        es = 1'b0;
        if (m.dpos >= 0) begin
            if (v) n.filled = m.filled + 1;
            else begin
                if (m.filled > 0) es = 1'b1;
                n.filled = 0;
            end
            n.dpos = (m.dpos == d - 1) ? -1 : m.dpos + 1;
        end else if (v) begin
            n.filled = m.filled + 1;
            if (n.filled == 2 * d) begin
                n.filled = 0;
                n.dpos   = 0;
            end
        end else begin
            if (m.filled > 0) es = 1'b1;
            n.filled = 0;
        end
        n.err = es ? 1'b1 : (clr ? 1'b0 : m.err);
        return n;
    endfunction

    task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b want=%b", nm, $time, act, exp);
        end
    endtask

    task automatic hc(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            if (!rst_n) begin
                m8 = mdl_reset();
                m1 = mdl_reset();
            end
            chk("model_d8", o8, mdl_out(m8, 8, 2, v8));
            chk("model_d1", o1, mdl_out(m1, 1, 16, v1));
            if (rst_n) begin
                m8 = mdl_step(m8, 8, v8, c8);
                m1 = mdl_step(m1, 1, v1, c1);
            end
        end
    end

    task automatic tick(input bit v, input bit c, input bit r, input bit w1);
        @(posedge clk);
        #1;
        v8    = v;
        c8    = c;
        rst_n = r;
        v1    = w1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        v8 = 1'b0; c8 = 1'b0; v1 = 1'b0; c1 = 1'b0;
        m8 = mdl_reset();
        m1 = mdl_reset();
        repeat (3) @(posedge clk);
        cmp_on = 1'b1;
        @(negedge clk);
        hc("rst_state", int'(st8), 0);
        hc("rst_valid", int'(vo8), 0);
        hc("rst_err",   int'(er8), 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);

        // Single frame
        for (int t = 0; t < 30; t++) begin
            tick(t < 16, 0, 1, 0);
            if (t == 7)  hc("t1_vo7",   int'(vo8), 0);
            if (t == 8)  hc("t1_bf8",   int'(bf8), 1);
            if (t == 8)  hc("t1_vo8",   int'(vo8), 1);
            if (t == 16) hc("t1_st16",  int'(st8), 3);
            if (t == 17) hc("t1_ad17",  int'(ad8), 2);
            if (t == 23) hc("t1_ad23",  int'(ad8), 14);
            if (t == 23) hc("t1_fd23",  int'(fd8), 1);
            if (t == 24) hc("t1_st24",  int'(st8), 0);
            if (t == 24) hc("t1_err24", int'(er8), 0);
        end

        // Three back-to-back frames
        for (int t = 0; t < 60; t++) begin
            tick(t < 48, 0, 1, 0);
            if (t == 23) hc("t2_st23", int'(st8), 3);
            if (t == 24) hc("t2_st24", int'(st8), 2);
            if (t == 40) hc("t2_st40", int'(st8), 2);
            if (t == 39) hc("t2_fd39", int'(fd8), 1);
            if (t == 55) hc("t2_fd55", int'(fd8), 1);
            if (t == 55) hc("t2_vo55", int'(vo8), 1);
            if (t == 56) hc("t2_vo56", int'(vo8), 0);
        end

        // Next frame starts during drain
        for (int t = 0; t < 50; t++) begin
            tick((t < 16) || (t >= 20 && t < 36), 0, 1, 0);
            if (t == 24) hc("t3_st24", int'(st8), 1);
            if (t == 27) hc("t3_st27", int'(st8), 1);
            if (t == 28) hc("t3_st28", int'(st8), 2);
            if (t == 44) hc("t3_st44", int'(st8), 0);
        end

        // Protocol errors and clearing
        for (int t = 0; t < 70; t++) begin
            tick((t < 11) || (t >= 20 && t < 23) || (t >= 40 && t < 56) ||
                 (t == 58) || (t == 59),
                 (t == 14) || (t == 23) || (t == 26), 1, 0);
            if (t == 11) hc("t4_vo11",  int'(vo8), 0);
            if (t == 12) hc("t4_err12", int'(er8), 1);
            if (t == 12) hc("t4_st12",  int'(st8), 0);
            if (t == 14) hc("t4_err14", int'(er8), 1);
            if (t == 15) hc("t4_err15", int'(er8), 0);
            if (t == 24) hc("t4_err24", int'(er8), 1);
            if (t == 27) hc("t4_err27", int'(er8), 0);
            if (t == 60) hc("t4_ad60",  int'(ad8), 8);
            if (t == 61) hc("t4_err61", int'(er8), 1);
            if (t == 61) hc("t4_st61",  int'(st8), 3);
            if (t == 63) hc("t4_fd63",  int'(fd8), 1);
            if (t == 64) hc("t4_st64",  int'(st8), 0);
        end

        // Asynchronous reset during drain, then a fresh frame
        for (int t = 0; t < 50; t++) begin
            tick((t < 16) || (t >= 22 && t < 38), 0, (t != 18), 0);
            if (t == 17) hc("t5_st17",  int'(st8), 3);
            if (t == 18) hc("t5_st18",  int'(st8), 0);
            if (t == 18) hc("t5_vo18",  int'(vo8), 0);
            if (t == 18) hc("t5_twe18", int'(twe8), 0);
            if (t == 18) hc("t5_ad18",  int'(ad8), 0);
            if (t == 18) hc("t5_sh18",  int'(sh8), 0);
            if (t == 29) hc("t5_bf29",  int'(bf8), 0);
            if (t == 30) hc("t5_bf30",  int'(bf8), 1);
            if (t == 45) hc("t5_fd45",  int'(fd8), 1);
            if (t == 46) hc("t5_st46",  int'(st8), 0);
        end

        // DELAY=1 stage
        for (int t = 0; t < 6; t++) begin
            tick(0, 0, 1, (t < 2));
            if (t == 0) hc("t6_st0", int'(st1), 0);
            if (t == 1) hc("t6_st1", int'(st1), 2);
            if (t == 1) hc("t6_vo1", int'(vo1), 1);
            if (t == 2) hc("t6_st2", int'(st1), 3);
            if (t == 2) hc("t6_ad2", int'(ad1), 0);
            if (t == 2) hc("t6_fd2", int'(fd1), 1);
            if (t == 3) hc("t6_st3", int'(st1), 0);
            if (t == 3) hc("t6_vo3", int'(vo1), 0);
        end

        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
